// File: rtl/dcache_victim_ctrl.sv
// Purpose: dcache-side victim cache controller: probe on miss, memory fetch on victim miss, victim write of evicted line, fill response.
// Latency: acceptance to resp_valid_o is 2 cycles (victim hit), +1 with evict write; victim miss is 2 + memory latency (+1 with evict).
// Backpressure: ready_o low while busy or flushing; the fill is held on resp_* until resp_ready_i, memory request held until mem_ack_i.
module dcache_victim_ctrl #(
    parameter int DCACHE_LINE_WIDTH = 128,
    parameter int VICTIM_ADDR_BITS  = 28,
    parameter int STAT_WIDTH        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         req_i,
    output logic                         ready_o,
    input  logic [VICTIM_ADDR_BITS-1:0]  miss_addr_i,
    input  logic                         evict_valid_i,
    input  logic [VICTIM_ADDR_BITS-1:0]  evict_addr_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [DCACHE_LINE_WIDTH-1:0] resp_data_o,
    output logic                         resp_victim_hit_o,
    output logic [DCACHE_LINE_WIDTH-1:0] dcache2victim_data_o,
    output logic [VICTIM_ADDR_BITS-1:0]  dcache2victim_addr_o,
    output logic                         victim_wr_en_o,
    output logic                         victim_flush_o,
    input  logic [DCACHE_LINE_WIDTH-1:0] victim2dcache_data_i,
    input  logic                         victim_hit_i,
    output logic                         mem_req_o,
    output logic [VICTIM_ADDR_BITS-1:0]  mem_addr_o,
    input  logic                         mem_ack_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] mem_data_i,
    output logic [STAT_WIDTH-1:0]        hit_cnt_o,
    output logic [STAT_WIDTH-1:0]        miss_cnt_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PROBE     = 3'd1,
        MEM_REQ   = 3'd2,
        WR_VICTIM = 3'd3,
        RESP      = 3'd4,
        FLUSH     = 3'd5
    } state_t;

    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

    state_t state_q, state_nxt;

    logic [VICTIM_ADDR_BITS-1:0]  miss_addr_q;
    logic                         evict_valid_q;
    logic [VICTIM_ADDR_BITS-1:0]  evict_addr_q;
    logic [DCACHE_LINE_WIDTH-1:0] evict_data_q;
    logic [DCACHE_LINE_WIDTH-1:0] line_q;
    logic                         src_hit_q;
    logic                         flush_pend_q;
    logic [STAT_WIDTH-1:0]        hit_cnt_q;
    logic [STAT_WIDTH-1:0]        miss_cnt_q;

    // An evicted line with the same address as the miss is about to be refilled,
    // so writing it into the victim cache would only duplicate the line.
    logic evict_eff;
    assign evict_eff = evict_valid_q && (evict_addr_q != miss_addr_q);

    // A simultaneous flush takes priority, so the request is only taken without one.
    logic accept;
    assign accept = (state_q == IDLE) && req_i && !flush_pend_q && !flush_i;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and output decode; every output is a pure function of state and held registers.
    always_comb begin
        state_nxt            = state_q;
        ready_o              = 1'b0;
        resp_valid_o         = 1'b0;
        resp_data_o          = '0;
        resp_victim_hit_o    = 1'b0;
        dcache2victim_data_o = '0;
        dcache2victim_addr_o = '0;
        victim_wr_en_o       = 1'b0;
        victim_flush_o       = 1'b0;
        mem_req_o            = 1'b0;
        mem_addr_o           = '0;
        case (state_q)
            IDLE: begin
                ready_o = !flush_pend_q;
                if (flush_i || flush_pend_q) begin
                    state_nxt = FLUSH;
                end else if (req_i) begin
                    state_nxt = PROBE;
                end
            end
            PROBE: begin
                dcache2victim_addr_o = miss_addr_q;
                if (victim_hit_i) begin
                    state_nxt = evict_eff ? WR_VICTIM : RESP;
                end else begin
                    state_nxt = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = miss_addr_q;
                if (mem_ack_i) begin
                    state_nxt = evict_eff ? WR_VICTIM : RESP;
                end
            end
            WR_VICTIM: begin
                victim_wr_en_o       = 1'b1;
                dcache2victim_addr_o = evict_addr_q;
                dcache2victim_data_o = evict_data_q;
                state_nxt            = RESP;
            end
            RESP: begin
                resp_valid_o      = 1'b1;
                resp_data_o       = line_q;
                resp_victim_hit_o = src_hit_q;
                if (resp_ready_i) begin
                    state_nxt = (flush_pend_q || flush_i) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                victim_flush_o = 1'b1;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture: miss address and evicted line are held for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_addr_q   <= '0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
            evict_data_q  <= '0;
        end else if (accept) begin
            miss_addr_q   <= miss_addr_i;
            evict_valid_q <= evict_valid_i;
            evict_addr_q  <= evict_addr_i;
            evict_data_q  <= evict_data_i;
        end
    end

    // Fill line buffer and its source flag, loaded from the victim on a probe hit or from memory on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q    <= '0;
            src_hit_q <= 1'b0;
        end else if ((state_q == PROBE) && victim_hit_i) begin
            line_q    <= victim2dcache_data_i;
            src_hit_q <= 1'b1;
        end else if ((state_q == MEM_REQ) && mem_ack_i) begin
            line_q    <= mem_data_i;
            src_hit_q <= 1'b0;
        end
    end

    // Flush pending: any flush seen while busy is remembered (merged) until the FLUSH cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend_q <= 1'b0;
        end else if (state_q == FLUSH) begin
            flush_pend_q <= 1'b0;
        end else if ((state_q != IDLE) && flush_i) begin
            flush_pend_q <= 1'b1;
        end
    end

    // Saturating hit/miss statistics, counted once per probe; flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == PROBE) begin
            if (victim_hit_i) begin
                if (hit_cnt_q != STAT_MAX) begin
                    hit_cnt_q <= hit_cnt_q + STAT_WIDTH'(1);
                end
            end else begin
                if (miss_cnt_q != STAT_MAX) begin
                    miss_cnt_q <= miss_cnt_q + STAT_WIDTH'(1);
                end
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_victim_ctrl.sv
// Purpose: self-checking bench for dcache_victim_ctrl with victim-cache and memory environment models.
// Latency: checks acceptance-to-response latency per transaction against the expected path length.
// Backpressure: randomly stalls resp_ready_i and checks the held response stays stable.
module tb_dcache_victim_ctrl;

    localparam int LW   = 128;
    localparam int AW   = 28;
    localparam int SW   = 8;
    localparam int SMAX = (1 << SW) - 1;
    localparam int VN   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          req_i = 1'b0;
    logic          ready_o;
    logic [AW-1:0] miss_addr_i = '0;
    logic          evict_valid_i = 1'b0;
    logic [AW-1:0] evict_addr_i = '0;
    logic [LW-1:0] evict_data_i = '0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic [LW-1:0] resp_data_o;
    logic          resp_victim_hit_o;
    logic [LW-1:0] dcache2victim_data_o;
    logic [AW-1:0] dcache2victim_addr_o;
    logic          victim_wr_en_o;
    logic          victim_flush_o;
    logic [LW-1:0] victim2dcache_data_i;
    logic          victim_hit_i;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_ack_i = 1'b0;
    logic [LW-1:0] mem_data_i = '0;
    logic [SW-1:0] hit_cnt_o;
    logic [SW-1:0] miss_cnt_o;

    int checks = 0;
    int errors = 0;

    dcache_victim_ctrl #(
        .DCACHE_LINE_WIDTH(LW),
        .VICTIM_ADDR_BITS (AW),
        .STAT_WIDTH       (SW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (flush_i),
        .req_i               (req_i),
        .ready_o             (ready_o),
        .miss_addr_i         (miss_addr_i),
        .evict_valid_i       (evict_valid_i),
        .evict_addr_i        (evict_addr_i),
        .evict_data_i        (evict_data_i),
        .resp_valid_o        (resp_valid_o),
        .resp_ready_i        (resp_ready_i),
        .resp_data_o         (resp_data_o),
        .resp_victim_hit_o   (resp_victim_hit_o),
        .dcache2victim_data_o(dcache2victim_data_o),
        .dcache2victim_addr_o(dcache2victim_addr_o),
        .victim_wr_en_o      (victim_wr_en_o),
        .victim_flush_o      (victim_flush_o),
        .victim2dcache_data_i(victim2dcache_data_i),
        .victim_hit_i        (victim_hit_i),
        .mem_req_o           (mem_req_o),
        .mem_addr_o          (mem_addr_o),
        .mem_ack_i           (mem_ack_i),
        .mem_data_i          (mem_data_i),
        .hit_cnt_o           (hit_cnt_o),
        .miss_cnt_o          (miss_cnt_o)
    );

    always #5 clk = ~clk;

    // Victim cache environment: small fully-associative store, FIFO replacement.
    logic [AW-1:0] vc_tag [VN] = '{default: '0};
    logic [LW-1:0] vc_dat [VN] = '{default: '0};
    logic          vc_v   [VN] = '{default: 1'b0};
    int            vc_ptr = 0;
    int            wr_seen = 0;
    int            flush_seen = 0;
    logic [AW-1:0] wr_last_a = '0;
    logic [LW-1:0] wr_last_d = '0;

    // Combinational victim read port; hit is only meaningful while not writing.
    always_comb begin
        victim_hit_i         = 1'b0;
        victim2dcache_data_i = '0;
        for (int i = 0; i < VN; i++) begin
            if (vc_v[i] && (vc_tag[i] == dcache2victim_addr_o) && !victim_wr_en_o) begin
                victim_hit_i         = 1'b1;
                victim2dcache_data_i = vc_dat[i];
            end
        end
    end

    // Victim cache write / flush side.
    always @(posedge clk) begin
        if (victim_flush_o) begin
            for (int i = 0; i < VN; i++) vc_v[i] = 1'b0;
            flush_seen++;
        end
        if (victim_wr_en_o) begin
            int slot;
            slot = -1;
            for (int i = 0; i < VN; i++)
                if (vc_v[i] && vc_tag[i] == dcache2victim_addr_o) slot = i;
            if (slot < 0) begin
                slot   = vc_ptr;
                vc_ptr = (vc_ptr + 1) % VN;
            end
            vc_v[slot]   = 1'b1;
            vc_tag[slot] = dcache2victim_addr_o;
            vc_dat[slot] = dcache2victim_data_o;
            wr_seen++;
            wr_last_a = dcache2victim_addr_o;
            wr_last_d = dcache2victim_data_o;
        end
    end

    // Memory environment: acks on the (mem_lat+1)-th cycle of a request.
    int            mem_lat = 0;
    logic [LW-1:0] mem_line = '0;
    int            mem_wait = 0;
    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (rst) begin
            mem_wait = 0;
        end else if (mem_req_o) begin
            if (mem_wait >= mem_lat) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mem_line;
                mem_wait   = 0;
            end else begin
                mem_wait++;
            end
        end
    end

    // Reference statistics.
    int hit_m = 0;
    int miss_m = 0;

    function automatic bit model_lookup(input logic [AW-1:0] a, output logic [LW-1:0] d);
        model_lookup = 1'b0;
        d = '0;
        for (int i = 0; i < VN; i++) begin
            if (vc_v[i] && vc_tag[i] == a) begin
                model_lookup = 1'b1;
                d = vc_dat[i];
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete miss transaction, checked end to end against the reference expectations.
    task automatic do_req(input logic [AW-1:0] a, input bit ev_v, input logic [AW-1:0] ev_a,
                          input logic [LW-1:0] ev_d, input int lat, input logic [LW-1:0] mline,
                          input int stall, input bit flush_mid);
        logic [LW-1:0] vd, exp_d;
        bit eh, ew;
        int exp_lat, n, w0;
        eh      = model_lookup(a, vd);
        ew      = ev_v && (ev_a != a);
        exp_d   = eh ? vd : mline;
        exp_lat = eh ? (2 + int'(ew)) : (3 + lat + int'(ew));
        if (eh) hit_m = (hit_m < SMAX) ? hit_m + 1 : SMAX;
        else    miss_m = (miss_m < SMAX) ? miss_m + 1 : SMAX;
        mem_lat  = lat;
        mem_line = mline;
        w0       = wr_seen;

        req_i         = 1'b1;
        miss_addr_i   = a;
        evict_valid_i = ev_v;
        evict_addr_i  = ev_a;
        evict_data_i  = ev_d;
        chk("ready_before_req", ready_o, 1);
        @(posedge clk);
        @(negedge clk);
        req_i         = 1'b0;
        evict_valid_i = $urandom_range(0, 1);
        evict_addr_i  = $urandom;
        evict_data_i  = {4{$urandom}};
        miss_addr_i   = $urandom;
        n = 1;
        chk("probe_addr", dcache2victim_addr_o, a);
        chk("probe_no_wr", victim_wr_en_o, 0);
        while (!resp_valid_o && n < 100) begin
            flush_i = flush_mid && (n == 2);
            @(negedge clk);
            n++;
        end
        flush_i = 1'b0;
        chk("resp_latency", n, exp_lat);
        chk("resp_data", resp_data_o, exp_d);
        chk("resp_victim_hit", resp_victim_hit_o, eh);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", resp_valid_o, 1);
            chk("stall_data", resp_data_o, exp_d);
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready_i = 1'b0;
        chk("resp_dropped", resp_valid_o, 0);
        if (flush_mid) begin
            chk("flush_pulse", victim_flush_o, 1);
            chk("flush_ready_low", ready_o, 0);
            @(negedge clk);
            chk("flush_single", victim_flush_o, 0);
        end else begin
            chk("no_flush", victim_flush_o, 0);
        end
        chk("ready_after", ready_o, 1);
        chk("wr_count", wr_seen - w0, int'(ew));
        if (ew) begin
            chk("wr_addr", wr_last_a, ev_a);
            chk("wr_data", wr_last_d, ev_d);
        end
        chk("hit_cnt", hit_cnt_o, hit_m);
        chk("miss_cnt", miss_cnt_o, miss_m);
    endtask

    initial begin
        int w0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready_o, 1);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_flush", victim_flush_o, 0);
        chk("rst_hit_cnt", hit_cnt_o, 0);
        chk("rst_miss_cnt", miss_cnt_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // Preload 0x123 through a miss that evicts it, then hit on it.
        do_req(28'h0000999, 1'b1, 28'h0000123, {16{8'hA5}}, 1, {16{8'h77}}, 0, 1'b0);
        do_req(28'h0000123, 1'b0, 28'h0, '0, 0, '0, 0, 1'b0);
        // Victim miss with evict, memory acks on the 4th request cycle.
        do_req(28'h0000456, 1'b1, 28'h0000789, {16{8'h3C}}, 3, {16{8'h11}}, 1, 1'b0);
        // Victim hit with evict: write follows the probe, data is the pre-write line.
        do_req(28'h0000123, 1'b1, 28'h0000321, {16{8'h5A}}, 0, '0, 0, 1'b0);
        // Evict address equals miss address: write suppressed.
        do_req(28'h0000AAA, 1'b1, 28'h0000AAA, {16{8'hEE}}, 0, {16{8'h22}}, 2, 1'b0);
        // Flush during MEM_REQ: single flush pulse after the handshake.
        do_req(28'h0000555, 1'b0, 28'h0, '0, 3, {16{8'h33}}, 0, 1'b1);

        // Request and flush together in IDLE: flush wins, no probe.
        req_i = 1'b1;
        flush_i = 1'b1;
        miss_addr_i = 28'h0000222;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        flush_i = 1'b0;
        chk("idle_flush_pulse", victim_flush_o, 1);
        chk("idle_flush_ready", ready_o, 0);
        chk("idle_flush_no_probe", dcache2victim_addr_o, 0);
        @(negedge clk);
        chk("idle_flush_done", victim_flush_o, 0);
        chk("idle_flush_miss_cnt", miss_cnt_o, miss_m);

        // Random traffic over a small address pool.
        for (int t = 0; t < 60; t++) begin
            do_req(28'h100 + 28'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                   28'h100 + 28'($urandom_range(0, 11)), {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 4), {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 2), 1'($urandom_range(0, 7) == 0));
        end

        // Drive hits until the hit counter saturates.
        do_req(28'h0000777, 1'b1, 28'h0000123, {16{8'hA5}}, 0, {16{8'h44}}, 0, 1'b0);
        for (int t = 0; t < SMAX + 3; t++) begin
            do_req(28'h0000123, 1'b0, 28'h0, '0, 0, '0, 0, 1'b0);
        end
        chk("hit_saturated", hit_cnt_o, SMAX);

        // Reset during MEM_REQ aborts the transaction.
        mem_lat = 30;
        req_i = 1'b1;
        miss_addr_i = 28'hFFFFFFF;
        evict_valid_i = 1'b1;
        evict_addr_i = 28'h0000BBB;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        @(negedge clk);
        chk("abort_in_mem_req", mem_req_o, 1);
        w0 = wr_seen;
        rst = 1'b1;
        #1;
        chk("abort_mem_req_low", mem_req_o, 0);
        chk("abort_ready", ready_o, 1);
        chk("abort_hit_cnt", hit_cnt_o, 0);
        @(negedge clk);
        rst = 1'b0;
        hit_m = 0;
        miss_m = 0;
        repeat (3) @(negedge clk);
        chk("abort_no_mem_req", mem_req_o, 0);
        chk("abort_no_wr", wr_seen - w0, 0);
        chk("abort_no_resp", resp_valid_o, 0);
        do_req(28'h0000456, 1'b0, 28'h0, '0, 1, {16{8'h66}}, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
